stream_demux: RTL and testbench

// - 1:N stream router; the opposite end of the N:1 priority arbiter.
// - Takes one valid/ready stream plus a destination index (e.g. an upstream
//   io_chosen) and steers each beat to one of N output lanes.
// - Each lane has a one-entry output register: 1-cycle latency, full throughput
//   per lane, and a stalled lane does not block beats to other lanes.

---
 rtl/stream_demux_if.sv | 36 +++
 rtl/stream_demux.sv | 109 ++++++++++
 tb/tb_stream_demux.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// ---------------------------------------------------------------------------
// stream_demux_if
// Bundle of the handshake/bus signals of the 1:N stream demultiplexer.
//   io_in_valid / io_in_ready / io_in_bits / io_in_dest : upstream beat
//   io_out_valid[k] / io_out_ready[k] / io_out_bits[k]  : output lane k
//   io_drop  : one-cycle pulse after an out-of-range beat was discarded
//   io_count : accepted-beat counter (zero unless DEMUX_CNT_EN is defined)
// Modports:
//   master : the environment (upstream producer + lane consumers)
//   slave  : the demultiplexer itself
// ---------------------------------------------------------------------------
interface stream_demux_if #(
    parameter int WIDTH  = 8,
    parameter int N      = 4,
    parameter int DEST_W = 2
) ();
    logic                    io_in_valid;
    logic                    io_in_ready;
    logic [WIDTH-1:0]        io_in_bits;
    logic [DEST_W-1:0]       io_in_dest;
    logic [N-1:0]            io_out_valid;
    logic [N-1:0]            io_out_ready;
    logic [N-1:0][WIDTH-1:0] io_out_bits;
    logic                    io_drop;
    logic [15:0]             io_count;

    modport master (
        output io_in_valid, io_in_bits, io_in_dest, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_drop, io_count
    );

    modport slave (
        input  io_in_valid, io_in_bits, io_in_dest, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_drop, io_count
    );
endinterface

// File: rtl/stream_demux.sv
// ---------------------------------------------------------------------------
// stream_demux
// 1:N stream router. Each input beat is steered to the lane named by
// io_in_dest; every lane owns a one-entry output register, giving 1-cycle
// latency, full per-lane throughput and no head-of-line blocking between
// lanes. Beats whose destination is >= N are accepted and discarded, and
// io_drop pulses in the following cycle.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : synchronous, active-high
//   io     : stream_demux_if.slave (input stream, N output lanes, drop, count)
// Configuration macro:
//   DEMUX_CNT_EN : when defined, io_count counts accepted in-range beats
//                  (16-bit, wrapping); when undefined io_count is 16'h0000.
// ---------------------------------------------------------------------------
module stream_demux #(
    parameter int WIDTH  = 8,
    parameter int N      = 4,
    parameter int DEST_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    stream_demux_if.slave io
);

    logic [N-1:0]            hit_s;
    logic                    oob_s;
    logic                    ready_s;
    logic                    in_fire_s;
    logic [N-1:0]            vld_r;
    logic [N-1:0][WIDTH-1:0] dat_r;
    logic                    drop_r;

    // Decode the destination index into a one-hot lane select
    always_comb begin
        hit_s = '0;
        for (int k = 0; k < N; k++) begin
            if (io.io_in_dest == DEST_W'(k)) begin
                hit_s[k] = 1'b1;
            end else begin
                hit_s[k] = 1'b0;
            end
        end
    end

    // An index that selects no lane is out of range and will be dropped
    assign oob_s = ~|hit_s;

    // Ready depends only on dest and lane state; an out-of-range dest selects
    // no lane, so every term is 1 and the beat is always taken.
    assign ready_s   = &(~hit_s | ~vld_r | io.io_out_ready);
    assign in_fire_s = io.io_in_valid & ready_s;

    // Per-lane output register: refill wins over drain, so a lane draining
    // and receiving in the same cycle stays valid with the new payload
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_r <= '0;
            dat_r <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (in_fire_s && hit_s[k]) begin
                    vld_r[k] <= 1'b1;
                    dat_r[k] <= io.io_in_bits;
                end else if (vld_r[k] && io.io_out_ready[k]) begin
                    vld_r[k] <= 1'b0;
                    dat_r[k] <= dat_r[k];
                end else begin
                    vld_r[k] <= vld_r[k];
                    dat_r[k] <= dat_r[k];
                end
            end
        end
    end

    // Drop indicator, one cycle after an out-of-range beat is discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= in_fire_s & oob_s;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] count_r;

    // Accepted-beat counter; discarded beats are not counted, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 16'h0000;
        end else if (in_fire_s && !oob_s) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign io.io_count = count_r;
`else
    assign io.io_count = 16'h0000;
`endif

    assign io.io_in_ready  = ready_s;
    assign io.io_out_valid = vld_r;
    assign io.io_out_bits  = dat_r;
    assign io.io_drop      = drop_r;

endmodule

// File: tb/tb_stream_demux.sv
// ---------------------------------------------------------------------------
// tb_stream_demux
// Self-checking bench for stream_demux. Two instances: a 4-lane one for the
// directed lane scenarios and the counter wrap, and a 3-lane one where
// dest=3 is out of range (drop behaviour and randomized traffic against a
// lane-occupancy reference model). Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_stream_demux;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [15:0] c4;

    stream_demux_if #(.WIDTH(8), .N(4), .DEST_W(2)) if4 ();
    stream_demux_if #(.WIDTH(8), .N(3), .DEST_W(2)) if3 ();

    stream_demux #(.WIDTH(8), .N(4), .DEST_W(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .io    (if4)
    );

    stream_demux #(.WIDTH(8), .N(3), .DEST_W(2)) dut3 (
        .clk   (clk),
        .reset (reset),
        .io    (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected io_count given the number of accepted in-range beats
    function automatic logic [15:0] cnt_exp(input logic [15:0] n);
`ifdef DEMUX_CNT_EN
        return n;
`else
        return 16'h0000 & n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if4.io_in_valid  = 1'b0;
        if4.io_in_bits   = 8'h00;
        if4.io_in_dest   = 2'd0;
        if4.io_out_ready = 4'b0000;
        if3.io_in_valid  = 1'b0;
        if3.io_in_bits   = 8'h00;
        if3.io_in_dest   = 2'd0;
        if3.io_out_ready = 3'b000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        c4 = 16'h0000;
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 4; d++) begin
            if4.io_in_dest = 2'(d);
            #1;
            n_vec++;
            if (if4.io_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL reset_ready dest=%0d: got %b expected 1", d, if4.io_in_ready);
            end
        end
        if4.io_in_dest = 2'd0;
        @(negedge clk);
        n_vec++;
        if (if4.io_out_valid !== 4'b0000 || if3.io_out_valid !== 3'b000) begin
            n_err++;
            $display("FAIL reset_valid: got %b/%b expected 0000/000", if4.io_out_valid, if3.io_out_valid);
        end
        n_vec++;
        if (if4.io_count !== 16'h0000 || if4.io_drop !== 1'b0 || if3.io_drop !== 1'b0) begin
            n_err++;
            $display("FAIL reset_count_drop: got cnt=%h drop=%b/%b expected 0000 0/0",
                     if4.io_count, if4.io_drop, if3.io_drop);
        end
        tick();
    endtask

    task automatic test_basic();
        if4.io_out_ready = 4'b0000;
        if4.io_in_valid  = 1'b1;
        if4.io_in_bits   = 8'hA5;
        if4.io_in_dest   = 2'd2;
        @(negedge clk);
        n_vec++;
        if (if4.io_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_first_ready: got %b expected 1", if4.io_in_ready);
        end
        tick();
        c4++;
        if4.io_in_bits = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (if4.io_out_valid[2] !== 1'b1 || if4.io_out_bits[2] !== 8'hA5 || if4.io_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL basic_stall%0d: got v=%b bits=%h rdy=%b expected 1 a5 0",
                         i, if4.io_out_valid[2], if4.io_out_bits[2], if4.io_in_ready);
            end
            tick();
        end
        if4.io_out_ready[2] = 1'b1;
        @(negedge clk);
        n_vec++;
        if (if4.io_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_pass_ready: got %b expected 1", if4.io_in_ready);
        end
        tick();
        c4++;
        if4.io_in_valid     = 1'b0;
        if4.io_out_ready[2] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if4.io_out_valid[2] !== 1'b1 || if4.io_out_bits[2] !== 8'h5A) begin
            n_err++;
            $display("FAIL basic_refill: got v=%b bits=%h expected 1 5a",
                     if4.io_out_valid[2], if4.io_out_bits[2]);
        end
        tick();
        if4.io_out_ready[2] = 1'b1;
        tick();
        if4.io_out_ready[2] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if4.io_out_valid !== 4'b0000 || if4.io_count !== cnt_exp(c4)) begin
            n_err++;
            $display("FAIL basic_drain: got v=%b cnt=%h expected 0000 %h",
                     if4.io_out_valid, if4.io_count, cnt_exp(c4));
        end
        tick();
    endtask

    task automatic test_isolation();
        if4.io_out_ready = 4'b0000;
        if4.io_in_valid  = 1'b1;
        if4.io_in_bits   = 8'h77;
        if4.io_in_dest   = 2'd1;
        tick();
        c4++;
        if4.io_in_bits = 8'h3C;
        if4.io_in_dest = 2'd3;
        @(negedge clk);
        n_vec++;
        if (if4.io_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL iso_ready: got %b expected 1", if4.io_in_ready);
        end
        tick();
        c4++;
        if4.io_in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (if4.io_out_valid !== 4'b1010 || if4.io_out_bits[3] !== 8'h3C || if4.io_out_bits[1] !== 8'h77) begin
                n_err++;
                $display("FAIL iso_lanes%0d: got v=%b b3=%h b1=%h expected 1010 3c 77",
                         i, if4.io_out_valid, if4.io_out_bits[3], if4.io_out_bits[1]);
            end
            tick();
        end
        if4.io_out_ready = 4'b1111;
        tick();
        if4.io_out_ready = 4'b0000;
        @(negedge clk);
        n_vec++;
        if (if4.io_out_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL iso_drain: got %b expected 0000", if4.io_out_valid);
        end
        tick();
    endtask

    task automatic test_drain_refill();
        if4.io_out_ready = 4'b0000;
        if4.io_in_valid  = 1'b1;
        if4.io_in_bits   = 8'h22;
        if4.io_in_dest   = 2'd0;
        tick();
        c4++;
        if4.io_out_ready[0] = 1'b1;
        if4.io_in_bits      = 8'h11;
        @(negedge clk);
        n_vec++;
        if (if4.io_in_ready !== 1'b1 || if4.io_out_valid[0] !== 1'b1 || if4.io_out_bits[0] !== 8'h22) begin
            n_err++;
            $display("FAIL refill_pre: got rdy=%b v=%b bits=%h expected 1 1 22",
                     if4.io_in_ready, if4.io_out_valid[0], if4.io_out_bits[0]);
        end
        tick();
        c4++;
        if4.io_in_valid     = 1'b0;
        if4.io_out_ready[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if4.io_out_valid[0] !== 1'b1 || if4.io_out_bits[0] !== 8'h11) begin
            n_err++;
            $display("FAIL refill_post: got v=%b bits=%h expected 1 11",
                     if4.io_out_valid[0], if4.io_out_bits[0]);
        end
        tick();
        if4.io_out_ready[0] = 1'b1;
        tick();
        if4.io_out_ready[0] = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if4.io_out_valid !== 4'b0000 || if4.io_count !== cnt_exp(c4)) begin
            n_err++;
            $display("FAIL refill_end: got v=%b cnt=%h expected 0000 %h",
                     if4.io_out_valid, if4.io_count, cnt_exp(c4));
        end
        tick();
    endtask

    task automatic test_drop();
        if3.io_out_ready = 3'b000;
        if3.io_in_valid  = 1'b1;
        if3.io_in_bits   = 8'hFF;
        if3.io_in_dest   = 2'd3;
        @(negedge clk);
        n_vec++;
        if (if3.io_in_ready !== 1'b1 || if3.io_drop !== 1'b0) begin
            n_err++;
            $display("FAIL drop_accept: got rdy=%b drop=%b expected 1 0", if3.io_in_ready, if3.io_drop);
        end
        tick();
        if3.io_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if3.io_drop !== 1'b1 || if3.io_out_valid !== 3'b000 || if3.io_count !== 16'h0000) begin
            n_err++;
            $display("FAIL drop_pulse: got drop=%b v=%b cnt=%h expected 1 000 0000",
                     if3.io_drop, if3.io_out_valid, if3.io_count);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (if3.io_drop !== 1'b0) begin
            n_err++;
            $display("FAIL drop_once: got %b expected 0", if3.io_drop);
        end
        tick();
    endtask

    // Randomized traffic on the 3-lane build; the model tracks what each
    // lane buffer holds and how many beats were accepted.
    task automatic test_random();
        logic        m_vld [3];
        logic [7:0]  m_dat [3];
        logic        m_drop;
        logic [15:0] m_cnt;
        logic [2:0]  rdy;
        logic        vin;
        logic [7:0]  bin;
        logic        exp_rdy;
        logic        fire;
        int          d;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            m_vld[k] = 1'b0;
            m_dat[k] = 8'h00;
        end
        m_drop = 1'b0;
        m_cnt  = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            vin = 1'($urandom_range(0, 1));
            bin = 8'($urandom);
            d   = int'($urandom_range(0, 3));
            for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 2) != 0);
            if3.io_in_valid  = vin;
            if3.io_in_bits   = bin;
            if3.io_in_dest   = 2'(d);
            if3.io_out_ready = rdy;
            @(negedge clk);
            exp_rdy = (d >= 3) ? 1'b1 : (!m_vld[d] || rdy[d]);
            n_vec++;
            if (if3.io_in_ready !== exp_rdy || if3.io_drop !== m_drop || if3.io_count !== cnt_exp(m_cnt)) begin
                n_err++;
                $display("FAIL rand_ctl cyc=%0d: got rdy=%b drop=%b cnt=%h expected %b %b %h",
                         i, if3.io_in_ready, if3.io_drop, if3.io_count, exp_rdy, m_drop, cnt_exp(m_cnt));
            end
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (if3.io_out_valid[k] !== m_vld[k] || if3.io_out_bits[k] !== m_dat[k]) begin
                    n_err++;
                    $display("FAIL rand_lane%0d cyc=%0d: got v=%b bits=%h expected %b %h",
                             k, i, if3.io_out_valid[k], if3.io_out_bits[k], m_vld[k], m_dat[k]);
                end
            end
            fire = vin && exp_rdy;
            for (int k = 0; k < 3; k++) begin
                if (fire && d == k) begin
                    m_vld[k] = 1'b1;
                    m_dat[k] = bin;
                end else if (m_vld[k] && rdy[k]) begin
                    m_vld[k] = 1'b0;
                end
            end
            m_drop = fire && (d >= 3);
            if (fire && d < 3) m_cnt++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        if4.io_out_ready = 4'b1111;
        if4.io_in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            if4.io_in_dest = 2'($urandom_range(0, 3));
            if4.io_in_bits = 8'($urandom);
            tick();
        end
        if4.io_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if4.io_count !== cnt_exp(16'hFFFF)) begin
            n_err++;
            $display("FAIL wrap_max: got %h expected %h", if4.io_count, cnt_exp(16'hFFFF));
        end
        tick();
        if4.io_in_valid = 1'b1;
        tick();
        if4.io_in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if4.io_count !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_zero: got %h expected 0000", if4.io_count);
        end
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        c4    = 16'h0000;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_isolation();
        test_drain_refill();
        test_drop();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
